// File: rtl/gray_seq_ctrl_if.sv
// rtl/gray_seq_ctrl_if.sv - control/status bundle for the Gray-code sequencer
interface gray_seq_ctrl_if #(
  parameter int DIV_W = 16
);
  logic             start;
  logic             stop;
  logic             step;
  logic             clr;
  logic             dir;
  logic [DIV_W-1:0] div;
  logic [2:0]       led;
  logic             tick;
  logic             wrap;
  logic             busy;

  modport master (
    output start, stop, step, clr, dir, div,
    input  led, tick, wrap, busy
  );

  modport slave (
    input  start, stop, step, clr, dir, div,
    output led, tick, wrap, busy
  );
endinterface

// File: rtl/gray_seq_ctrl.sv
// rtl/gray_seq_ctrl.sv - 3-bit Gray-code sequencer with prescaled run and single-step modes
// Optional feature macro GRAY_SEQ_CTRL_DIR_EN enables down counting via dir.
module gray_seq_ctrl #(
  parameter int DIV_W = 16
) (
  input logic            clk,
  input logic            rst_n,
  gray_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [2:0]       bin, bin_d;
  logic [2:0]       led_q;
  logic [DIV_W-1:0] cnt, cnt_d;
  logic [DIV_W-1:0] div_q, div_q_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             adv;
  logic             down;

`ifdef GRAY_SEQ_CTRL_DIR_EN
  assign down = bus.dir;
`else
  logic unused_dir;
  assign unused_dir = bus.dir;
  assign down       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      bin    <= 3'd0;
      led_q  <= 3'b000;
      cnt    <= '0;
      div_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      state  <= state_d;
      bin    <= bin_d;
      led_q  <= bin_d ^ (bin_d >> 1);
      cnt    <= cnt_d;
      div_q  <= div_q_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  // clr dominates everything; it never moves the FSM except that STEP always
  // collapses back to IDLE after its single cycle.
  always_comb begin
    state_d = state;
    bin_d   = bin;
    cnt_d   = cnt;
    div_q_d = div_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    adv     = 1'b0;

    if (bus.clr) begin
      bin_d = 3'd0;
      cnt_d = '0;
      if (state == STEP) begin
        state_d = IDLE;
      end
    end else begin
      case (state)
        IDLE: begin
          if (!bus.stop) begin
            if (bus.start) begin
              state_d = RUN;
              div_q_d = bus.div;
              cnt_d   = '0;
            end else if (bus.step) begin
              state_d = STEP;
            end
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt == div_q) begin
            adv   = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt + DIV_W'(1);
          end
        end
        STEP: begin
          adv     = 1'b1;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Wrap is the binary rollover, which is the 100<->000 Gray transition.
    if (adv) begin
      tick_d = 1'b1;
      if (down) begin
        bin_d  = bin - 3'd1;
        wrap_d = (bin == 3'd0);
      end else begin
        bin_d  = bin + 3'd1;
        wrap_d = (bin == 3'd7);
      end
    end
  end

  assign bus.led  = led_q;
  assign bus.tick = tick_q;
  assign bus.wrap = wrap_q;
  assign bus.busy = (state == RUN);

endmodule

// File: doc/gray_seq_ctrl.md
GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

Interface
REQ-001 Parameter: DIV_W, 16, width of the prescaler divide value and counter.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  level; request free-running advance.
REQ-005 Port: stop  input  1  level; request return to idle.
REQ-006 Port: step  input  1  level; request one single advance while idle.
REQ-007 Port: clr  input  1  synchronous clear of the code value to 000.
REQ-008 Port: dir  input  1  0 = up, 1 = down; sampled on every advance.
REQ-009 Port: div  input  DIV_W  advance period minus one; latched on entry to RUN.
REQ-010 Port: led  output  3  registered 3-bit Gray code value.
REQ-011 Port: tick  output  1  registered one-cycle pulse coincident with each led change caused by an advance.
REQ-012 Port: wrap  output  1  registered one-cycle pulse when an advance crosses 100<->000.
REQ-013 Port: busy  output  1  high while in RUN.

Function
REQ-014 The block SHALL hold an internal 3-bit binary count bin; led SHALL equal bin ^ (bin >> 1) registered on the same edge as bin.
REQ-015 The up sequence SHALL be 000,001,011,010,110,111,101,100, then 000; down SHALL be the exact reverse.
REQ-016 The FSM SHALL have states IDLE, RUN, STEP.
REQ-017 Input priority each cycle SHALL be clr > stop > start > step.
REQ-018 IDLE: start -> RUN (latch div into div_q, prescaler cnt = 0); else step -> STEP; else stay.
REQ-019 STEP: advance once (tick = 1), then unconditionally -> IDLE; STEP SHALL last exactly one cycle.
REQ-020 RUN: cnt increments each cycle; when cnt == div_q, advance, pulse tick, cnt <- 0.
REQ-021 With div_q == 0 RUN SHALL advance every cycle; the first advance SHALL occur div_q+1 cycles after the cycle in which RUN is entered.
REQ-022 RUN: stop -> IDLE next edge, cnt <- 0, led holds, no advance in that cycle even if cnt == div_q.
REQ-023 step and start SHALL be ignored in RUN; div changes in RUN SHALL have no effect until the next entry.
REQ-024 clr SHALL set bin/led to 000 and cnt to 0, produce no tick or wrap, and leave the FSM state unchanged.
REQ-025 wrap SHALL pulse with tick when up goes 100->000 or down goes 000->100, and at no other time.
REQ-026 stop and start both high in IDLE SHALL leave the FSM in IDLE.

Reset
REQ-027 On rst_n low, asynchronously: state = IDLE, bin = 0, led = 000, cnt = 0, div_q = 0, tick = wrap = busy = 0.
REQ-028 A reset asserted mid-RUN or mid-STEP SHALL abort with no further advance; operation resumes only on a new start or step after release.

Configuration
REQ-029 Macro GRAY_SEQ_CTRL_DIR_EN: when defined, dir selects up or down per REQ-015.
REQ-030 When it is not defined, dir SHALL be ignored, counting SHALL be up only, and wrap SHALL pulse only on 100->000.

Verification
REQ-031 Reset: rst_n low mid-RUN at led=011 -> led=000, busy=0, tick=0 immediately, with no clock required.
REQ-032 Up run: div=2, start pulse -> tick every 3 cycles; led follows 001,011,010,110,111,101,100,000; wrap pulses with the 000 tick only.
REQ-033 Single step: in IDLE with led=000, step high for 1 cycle -> exactly one tick, led=001, FSM back in IDLE; holding step high -> one advance every 2 cycles.
REQ-034 Priority: clr+stop+start in RUN at led=110 -> led=000, no tick, FSM stays RUN; stop at cnt==div_q -> no advance, busy=0.
REQ-035 Down (macro defined): dir=1, div=0, start from 000 -> 100,101,111 on consecutive cycles, wrap on the first advance; macro undefined with the same stimulus -> 001,011,010, no wrap.
